// File: rtl/traffic_pkg.sv
// Shared definitions for the parameterised traffic-light controller:
// state encodings, state/timer widths and a counter-width helper.
package traffic_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TIMER_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_FLASH  = 3'd3
  } state_e;

  // Width of a counter that must hold the values 0..div-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk divider; emits a registered 1-clk tick once every DIV clks,
// first tick DIV clks after reset release.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned      CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;

  always_comb begin
    w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
  end

  // Tick is registered so it is high exactly while the count sits at DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/traffic_lights_param.sv
// Multi-phase traffic-light controller with pedestrian walk service and a
// night-time flashing-yellow mode; every output comes straight from a register.
module traffic_lights_param
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES   = 4,
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned PED_TICKS    = 10,
  parameter int unsigned TICK_DIV     = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         ped_req,
  input  logic                          night_mode,
  output logic [NUM_PHASES-1:0]         veh_red,
  output logic [NUM_PHASES-1:0]         veh_yel,
  output logic [NUM_PHASES-1:0]         veh_grn,
  output logic [NUM_PHASES-1:0]         ped_walk,
  output logic [STATE_W-1:0]            state,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [TIMER_W-1:0]            timer
);

  localparam int unsigned        PH_W       = $clog2(NUM_PHASES);
  localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(NUM_PHASES - 1);
  localparam logic [TIMER_W-1:0] T_GREEN    = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] T_YELLOW   = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] T_ALLRED   = TIMER_W'(ALLRED_TICKS - 1);
  localparam logic [TIMER_W-1:0] T_WALK_MIN = TIMER_W'(GREEN_TICKS - PED_TICKS);

  logic w_tick;

  state_e                r_state,   w_state_nxt;
  logic [PH_W-1:0]       r_phase,   w_phase_nxt;
  logic [TIMER_W-1:0]    r_timer,   w_timer_nxt;
  logic [NUM_PHASES-1:0] r_pending, w_pending_nxt;
  logic                  r_grant,   w_grant_nxt;
  logic                  r_flash,   w_flash_nxt;
  logic [NUM_PHASES-1:0] w_clr;
  logic [NUM_PHASES-1:0] w_oh_nxt;

  logic [NUM_PHASES-1:0] r_red,  w_red_nxt;
  logic [NUM_PHASES-1:0] r_yel,  w_yel_nxt;
  logic [NUM_PHASES-1:0] r_grn,  w_grn_nxt;
  logic [NUM_PHASES-1:0] r_walk, w_walk_nxt;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Next-state: states advance only on a tick whose timer has reached zero.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_timer_nxt = r_timer;
    w_grant_nxt = r_grant;
    w_flash_nxt = r_flash;
    w_clr       = '0;

    if (w_tick) begin
      if (r_timer != '0) begin
        w_timer_nxt = r_timer - TIMER_W'(1);
      end else begin
        case (r_state)
          ST_ALLRED: begin
            if (night_mode) begin
              w_state_nxt = ST_FLASH;
              w_timer_nxt = '0;
              w_flash_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_GREEN;
              w_timer_nxt = T_GREEN;
              w_grant_nxt = r_pending[r_phase];
              w_clr       = NUM_PHASES'(1) << r_phase;
            end
          end
          ST_GREEN: begin
            w_state_nxt = ST_YELLOW;
            w_timer_nxt = T_YELLOW;
            w_grant_nxt = 1'b0;
          end
          ST_YELLOW: begin
            w_state_nxt = ST_ALLRED;
            w_timer_nxt = T_ALLRED;
            w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
          end
          ST_FLASH: begin
            if (night_mode) begin
              w_flash_nxt = ~r_flash;
            end else begin
              w_state_nxt = ST_ALLRED;
              w_timer_nxt = T_ALLRED;
              w_phase_nxt = '0;
              w_flash_nxt = 1'b0;
            end
          end
          default: begin
            w_state_nxt = ST_ALLRED;
            w_timer_nxt = T_ALLRED;
            w_phase_nxt = '0;
          end
        endcase
      end
    end

    // A request landing on the green-entry edge is kept for the next green.
    w_pending_nxt = (r_pending & ~w_clr) | ped_req;
  end

  // Lamp decode from next-state values so the lamp registers track the state.
  always_comb begin
    w_oh_nxt   = NUM_PHASES'(1) << w_phase_nxt;
    w_red_nxt  = '0;
    w_yel_nxt  = '0;
    w_grn_nxt  = '0;
    w_walk_nxt = '0;
    case (w_state_nxt)
      ST_ALLRED: w_red_nxt = '1;
      ST_GREEN: begin
        w_grn_nxt = w_oh_nxt;
        w_red_nxt = ~w_oh_nxt;
        if (w_grant_nxt && (w_timer_nxt >= T_WALK_MIN)) begin
          w_walk_nxt = w_oh_nxt;
        end
      end
      ST_YELLOW: begin
        w_yel_nxt = w_oh_nxt;
        w_red_nxt = ~w_oh_nxt;
      end
      ST_FLASH:  w_yel_nxt = {NUM_PHASES{w_flash_nxt}};
      default:   w_red_nxt = '1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_ALLRED;
      r_phase   <= '0;
      r_timer   <= T_ALLRED;
      r_pending <= '0;
      r_grant   <= 1'b0;
      r_flash   <= 1'b0;
      r_red     <= '1;
      r_yel     <= '0;
      r_grn     <= '0;
      r_walk    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_timer   <= w_timer_nxt;
      r_pending <= w_pending_nxt;
      r_grant   <= w_grant_nxt;
      r_flash   <= w_flash_nxt;
      r_red     <= w_red_nxt;
      r_yel     <= w_yel_nxt;
      r_grn     <= w_grn_nxt;
      r_walk    <= w_walk_nxt;
    end
  end

  assign state    = r_state;
  assign phase    = r_phase;
  assign timer    = r_timer;
  assign veh_red  = r_red;
  assign veh_yel  = r_yel;
  assign veh_grn  = r_grn;
  assign ped_walk = r_walk;

endmodule

// File: tb/tb_traffic_lights_param.sv
// Bench for traffic_lights_param: a directed vector table, a reset corner
// sequence and random stimulus, all compared against a tick-level reference model.
module tb_traffic_lights_param;

  localparam int N   = 3;
  localparam int G   = 5;
  localparam int Y   = 2;
  localparam int A   = 1;
  localparam int PED = 3;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ped_req;
  logic        night_mode;
  logic [2:0]  veh_red, veh_yel, veh_grn, ped_walk;
  logic [2:0]  state;
  logic [1:0]  phase;
  logic [31:0] timer;

  int checks   = 0;
  int failures = 0;

  // Reference model: state code, phase, ticks left, prescaler count,
  // walk ticks left, flash lamp level and pending requests.
  int         m_st, m_ph, m_tm, m_cnt, m_walk;
  logic       m_flash;
  logic [2:0] m_pend;

  typedef struct {
    logic [2:0] ped;
    logic       night;
    int         n;
    int         st;
    int         ph;
    int         tm;
    logic [2:0] red;
    logic [2:0] yel;
    logic [2:0] grn;
    logic [2:0] walk;
  } vec_t;

  vec_t tbl [22];

  traffic_lights_param #(
    .NUM_PHASES   (N),
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .ALLRED_TICKS (A),
    .PED_TICKS    (PED),
    .TICK_DIV     (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .veh_red    (veh_red),
    .veh_yel    (veh_yel),
    .veh_grn    (veh_grn),
    .ped_walk   (ped_walk),
    .state      (state),
    .phase      (phase),
    .timer      (timer)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input int st, input int ph, input int tm,
                                       input logic [2:0] rd, input logic [2:0] yl,
                                       input logic [2:0] gn, input logic [2:0] wk);
    return {15'd0, 3'(st), 2'(ph), 32'(tm), rd, yl, gn, wk};
  endfunction

  function automatic logic [63:0] dut_vec();
    return pack(int'(state), int'(phase), int'(timer), veh_red, veh_yel, veh_grn, ped_walk);
  endfunction

  function automatic logic [63:0] model_vec();
    logic [2:0] oh, rd, yl, gn, wk;
    oh = 3'b001 << m_ph;
    rd = 3'b000; yl = 3'b000; gn = 3'b000; wk = 3'b000;
    case (m_st)
      0: rd = 3'b111;
      1: begin gn = oh; rd = ~oh; if (m_walk > 0) wk = oh; end
      2: begin yl = oh; rd = ~oh; end
      default: yl = {3{m_flash}};
    endcase
    return pack(m_st, m_ph, m_tm, rd, yl, gn, wk);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got st/ph/tm/lamps=%h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_tm = A - 1; m_cnt = 0; m_walk = 0;
    m_flash = 1'b0; m_pend = 3'b000;
  endtask

  // One clk edge of behaviour: tick every DIV clks, each state lasts its
  // duration in ticks, pending requests latched every clk.
  task automatic model_step(input logic [2:0] p, input logic n);
    logic       tk;
    logic [2:0] clr;
    tk    = (m_cnt == DIV - 1);
    m_cnt = (m_cnt + 1) % DIV;
    clr   = 3'b000;
    if (tk) begin
      if (m_st == 3) begin
        if (!n) begin m_st = 0; m_ph = 0; m_tm = A - 1; end
        else m_flash = ~m_flash;
      end else if (m_tm > 0) begin
        m_tm--;
        if (m_walk > 0) m_walk--;
      end else begin
        case (m_st)
          0: if (n) begin
               m_st = 3; m_tm = 0; m_flash = 1'b1;
             end else begin
               m_st = 1; m_tm = G - 1;
               m_walk = m_pend[m_ph] ? PED : 0;
               clr[m_ph] = 1'b1;
             end
          1: begin m_st = 2; m_tm = Y - 1; m_walk = 0; end
          default: begin m_st = 0; m_ph = (m_ph + 1) % N; m_tm = A - 1; end
        endcase
      end
    end
    m_pend = (m_pend & ~clr) | p;
  endtask

  // Advance one clk: inputs as currently driven are sampled at the rising edge.
  task automatic cycle();
    logic [2:0] p;
    logic       n, r;
    p = ped_req; n = night_mode; r = reset;
    @(posedge clk);
    if (!r) model_reset();
    else    model_step(p, n);
    @(negedge clk);
    check("model_cyc", dut_vec(), model_vec());
  endtask

  initial begin
    // {ped pulse, night, clks, state, phase, timer, red, yel, grn, walk}
    tbl[0]  = '{3'b000, 1'b0,  3, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b000, 1'b0,  1, 1, 0, 4, 3'b110, 3'b000, 3'b001, 3'b000};
    tbl[2]  = '{3'b100, 1'b0, 19, 1, 0, 0, 3'b110, 3'b000, 3'b001, 3'b000};
    tbl[3]  = '{3'b000, 1'b0,  1, 2, 0, 1, 3'b110, 3'b001, 3'b000, 3'b000};
    tbl[4]  = '{3'b000, 1'b0,  8, 0, 1, 0, 3'b111, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{3'b000, 1'b0,  4, 1, 1, 4, 3'b101, 3'b000, 3'b010, 3'b000};
    tbl[6]  = '{3'b010, 1'b0,  1, 1, 1, 4, 3'b101, 3'b000, 3'b010, 3'b000};
    tbl[7]  = '{3'b000, 1'b0, 31, 1, 2, 4, 3'b011, 3'b000, 3'b100, 3'b100};
    tbl[8]  = '{3'b000, 1'b0, 11, 1, 2, 2, 3'b011, 3'b000, 3'b100, 3'b100};
    tbl[9]  = '{3'b000, 1'b0,  1, 1, 2, 1, 3'b011, 3'b000, 3'b100, 3'b000};
    tbl[10] = '{3'b000, 1'b0, 20, 1, 0, 4, 3'b110, 3'b000, 3'b001, 3'b000};
    tbl[11] = '{3'b000, 1'b0, 32, 1, 1, 4, 3'b101, 3'b000, 3'b010, 3'b010};
    tbl[12] = '{3'b000, 1'b1,  1, 1, 1, 4, 3'b101, 3'b000, 3'b010, 3'b010};
    tbl[13] = '{3'b000, 1'b1, 27, 0, 2, 0, 3'b111, 3'b000, 3'b000, 3'b000};
    tbl[14] = '{3'b000, 1'b1,  4, 3, 2, 0, 3'b000, 3'b111, 3'b000, 3'b000};
    tbl[15] = '{3'b000, 1'b1,  4, 3, 2, 0, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[16] = '{3'b000, 1'b1,  3, 3, 2, 0, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[17] = '{3'b000, 1'b1,  1, 3, 2, 0, 3'b000, 3'b111, 3'b000, 3'b000};
    tbl[18] = '{3'b000, 1'b0,  4, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000};
    tbl[19] = '{3'b000, 1'b0,  4, 1, 0, 4, 3'b110, 3'b000, 3'b001, 3'b000};
    tbl[20] = '{3'b000, 1'b0, 64, 1, 2, 4, 3'b011, 3'b000, 3'b100, 3'b000};
    tbl[21] = '{3'b000, 1'b0, 22, 2, 2, 1, 3'b011, 3'b100, 3'b000, 3'b000};

    reset = 1'b1; ped_req = 3'b000; night_mode = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("reset_state", dut_vec(), pack(0, 0, A - 1, 3'b111, 3'b000, 3'b000, 3'b000));
    @(negedge clk);
    cycle();
    reset = 1'b1;

    // Directed timeline from reset release
    for (int i = 0; i < 22; i++) begin
      night_mode = tbl[i].night;
      ped_req    = tbl[i].ped;
      for (int k = 0; k < tbl[i].n; k++) begin
        cycle();
        ped_req = 3'b000;
      end
      check($sformatf("vec%0d", i), dut_vec(),
            pack(tbl[i].st, tbl[i].ph, tbl[i].tm, tbl[i].red, tbl[i].yel,
                 tbl[i].grn, tbl[i].walk));
    end

    // Reset mid-YELLOW(2): asynchronous, straight to all-red, never green
    reset = 1'b0;
    #1;
    model_reset();
    check("reset_async", dut_vec(), pack(0, 0, A - 1, 3'b111, 3'b000, 3'b000, 3'b000));
    @(negedge clk);
    cycle();
    check("reset_no_grn", {61'd0, veh_grn}, 64'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    check("first_tick_pre", dut_vec(), pack(0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000));
    cycle();
    check("first_tick_grn", dut_vec(), pack(1, 0, 4, 3'b110, 3'b000, 3'b001, 3'b000));

    // Random traffic, night toggling and occasional reset pulses
    for (int k = 0; k < 4000; k++) begin
      reset   = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      ped_req = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 249) == 0) night_mode = ~night_mode;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
